uart_report_formatter: RTL and testbench



---
 rtl/uart_report_pkg.sv | 32 +++
 rtl/bin2bcd_seq.sv | 52 +++++
 rtl/uart_report_formatter.sv | 180 ++++++++++++++++++
 tb/tb_uart_report_formatter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_report_pkg.sv
// Shared state encoding, ASCII constants and a decimal-limit helper for the UART report formatter.
// Pure declarations: no clocked logic and no flow control.
package uart_report_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_EMIT,
    ST_SEP,
    ST_CR,
    ST_LF
  } state_e;

  localparam logic [7:0] ASCII_C    = 8'h43;
  localparam logic [7:0] ASCII_EQ   = 8'h3D;
  localparam logic [7:0] ASCII_DASH = 8'h2D;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_1    = 8'h31;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] CMD_ALL    = 8'h41;
  localparam logic [7:0] CMD_PER    = 8'h50;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: the first bit is absorbed on start, done rises after DATA_W cycles.
// No backpressure; the result holds stable until the next start.
module bin2bcd_seq #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd
);
  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sh_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  adj;
  logic [CNT_W-1:0]  cnt_q;
  logic              active_q;

  always_comb begin
    adj = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
    end
  end

  // The first shift never needs add-3 (BCD is zero), so it is folded into the load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q     <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      bcd_q    <= BCD_W'(bin[DATA_W-1]);
      sh_q     <= bin << 1;
      cnt_q    <= CNT_W'(DATA_W - 1);
      active_q <= 1'b1;
    end else if (active_q && cnt_q != '0) begin
      bcd_q <= {adj[BCD_W-2:0], sh_q[DATA_W-1]};
      sh_q  <= sh_q << 1;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done = active_q && (cnt_q == '0);
  assign bcd  = bcd_q;

endmodule

// File: rtl/uart_report_formatter.sv
// Command-driven ASCII report generator feeding the UART TX FIFO; first byte DATA_W+1 cycles after the command.
// Bytes are pushed only while tx_full is low and the byte index advances only on a push.
module uart_report_formatter
  import uart_report_pkg::*;
#(
  parameter int         N_CH       = 4,
  parameter int         DATA_W     = 16,
  parameter int         DIGITS     = 5,
  parameter int         LEAD_BLANK = 0,
  parameter logic [7:0] SEP        = 8'h2C
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  input  logic [7:0]               cmd_data,
  input  logic                     report_tick,
  input  logic [N_CH*DATA_W-1:0]   field_data,
  input  logic [N_CH-1:0]          field_valid,
  input  logic                     tx_full,
  output logic                     tx_push,
  output logic [7:0]               tx_push_data,
  output logic                     busy,
  output logic                     periodic_en,
  output logic                     cmd_err,
  output logic                     cmd_drop
);
  localparam int          BCD_W    = DIGITS * 4;
  localparam logic [3:0]  LAST_IDX = 4'(DIGITS + 2);
  localparam logic [3:0]  LAST_FLD = 4'(N_CH - 1);
  localparam logic [63:0] SAT_LIM  = pow10(DIGITS);

  state_e                  state_q;
  logic [3:0]              fld_q, idx_q;
  logic                    all_q, periodic_q, busy_q, cmd_err_q, cmd_drop_q;
  logic [N_CH*DATA_W-1:0]  snap_dat_q;
  logic [N_CH-1:0]         snap_vld_q;

  logic                    is_digit, go_single, go_all, conv_start, conv_done;
  logic                    sat, cur_vld, found;
  logic [3:0]              first_fld, conv_fld, skip, dig;
  logic [DATA_W-1:0]       conv_bin, cur_val;
  logic [BCD_W-1:0]        bcd;
  logic [7:0]              emit_byte;

  assign tx_push = !tx_full && (state_q == ST_EMIT || state_q == ST_SEP ||
                                state_q == ST_CR   || state_q == ST_LF);

  always_comb begin
    is_digit   = (cmd_data >= ASCII_1) && (cmd_data <= ASCII_0 + 8'(N_CH));
    go_single  = (state_q == ST_IDLE) && cmd_valid && is_digit;
    // A command in the same cycle always beats the periodic tick.
    go_all     = (state_q == ST_IDLE) &&
                 ((cmd_valid && cmd_data == CMD_ALL) || (!cmd_valid && report_tick && periodic_q));
    first_fld  = go_single ? (cmd_data[3:0] - 4'd1) : 4'd0;
    conv_fld   = (state_q == ST_IDLE) ? first_fld : fld_q + 4'd1;
    conv_start = go_single || go_all || (state_q == ST_SEP && tx_push);

    conv_bin = '0;
    cur_val  = '0;
    cur_vld  = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (conv_fld == 4'(k))
        conv_bin = (state_q == ST_IDLE) ? field_data[k*DATA_W +: DATA_W]
                                        : snap_dat_q[k*DATA_W +: DATA_W];
      if (fld_q == 4'(k)) begin
        cur_val = snap_dat_q[k*DATA_W +: DATA_W];
        cur_vld = snap_vld_q[k];
      end
    end
    sat = 64'(cur_val) >= SAT_LIM;

    skip  = 4'd0;
    found = 1'b0;
    if (LEAD_BLANK != 0 && cur_vld && !sat) begin
      for (int d = 0; d < DIGITS - 1; d++) begin
        if (!found) begin
          if (bcd[(DIGITS-1-d)*4 +: 4] == 4'd0) skip = skip + 4'd1;
          else found = 1'b1;
        end
      end
    end

    dig = 4'd0;
    for (int d = 0; d < DIGITS; d++) begin
      if (idx_q == 4'(d + 3)) dig = bcd[(DIGITS-1-d)*4 +: 4];
    end

    case (idx_q)
      4'd0:    emit_byte = ASCII_C;
      4'd1:    emit_byte = ASCII_1 + {4'd0, fld_q};
      4'd2:    emit_byte = ASCII_EQ;
      default: emit_byte = !cur_vld ? ASCII_DASH : (sat ? ASCII_9 : ASCII_0 + {4'd0, dig});
    endcase

    case (state_q)
      ST_EMIT: tx_push_data = emit_byte;
      ST_SEP:  tx_push_data = SEP;
      ST_CR:   tx_push_data = ASCII_CR;
      ST_LF:   tx_push_data = ASCII_LF;
      default: tx_push_data = 8'h00;
    endcase
  end

  bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (conv_bin),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fld_q      <= '0;
      idx_q      <= '0;
      all_q      <= 1'b0;
      periodic_q <= 1'b0;
      busy_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
      cmd_drop_q <= 1'b0;
      snap_dat_q <= '0;
      snap_vld_q <= '0;
    end else begin
      cmd_err_q  <= 1'b0;
      cmd_drop_q <= cmd_valid && (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (go_single || go_all) begin
            state_q    <= ST_CONV;
            busy_q     <= 1'b1;
            fld_q      <= first_fld;
            all_q      <= go_all;
            snap_dat_q <= field_data;
            snap_vld_q <= field_valid;
          end else if (cmd_valid && cmd_data == CMD_PER) begin
            periodic_q <= !periodic_q;
          end else if (cmd_valid) begin
            cmd_err_q <= 1'b1;
          end
        end
        ST_CONV: begin
          if (conv_done) begin
            state_q <= ST_EMIT;
            idx_q   <= 4'd0;
          end
        end
        ST_EMIT: begin
          if (tx_push) begin
            if (idx_q == 4'd2) idx_q <= 4'd3 + skip;
            else if (idx_q == LAST_IDX)
              state_q <= (all_q && fld_q != LAST_FLD) ? ST_SEP : ST_CR;
            else idx_q <= idx_q + 4'd1;
          end
        end
        ST_SEP: begin
          if (tx_push) begin
            state_q <= ST_CONV;
            fld_q   <= fld_q + 4'd1;
          end
        end
        ST_CR: if (tx_push) state_q <= ST_LF;
        ST_LF: begin
          if (tx_push) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign periodic_en = periodic_q;
  assign cmd_err     = cmd_err_q;
  assign cmd_drop    = cmd_drop_q;

endmodule

// File: tb/tb_uart_report_formatter.sv
// Bench for uart_report_formatter: a default instance and a LEAD_BLANK=1/DIGITS=4 instance,
// each checked against a string-level reference model of the report format.
module tb_uart_report_formatter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_valid0, cmd_valid1, report_tick, tx_full0;
  logic [7:0]  cmd_data0, cmd_data1;
  logic [15:0] fv [4];
  logic [3:0]  fok;
  logic [63:0] field_data;

  logic        tx_push0, tx_push1, busy0, busy1, pen0, pen1, err0, err1, drop0, drop1;
  logic [7:0]  txd0, txd1;

  always_comb begin
    field_data = '0;
    for (int k = 0; k < 4; k++) field_data[k*16 +: 16] = fv[k];
  end

  uart_report_formatter dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_data(cmd_data0),
    .report_tick(report_tick), .field_data(field_data), .field_valid(fok),
    .tx_full(tx_full0), .tx_push(tx_push0), .tx_push_data(txd0), .busy(busy0),
    .periodic_en(pen0), .cmd_err(err0), .cmd_drop(drop0)
  );

  uart_report_formatter #(.DIGITS(4), .LEAD_BLANK(1)) dut_lb (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_data(cmd_data1),
    .report_tick(1'b0), .field_data(field_data), .field_valid(fok),
    .tx_full(1'b0), .tx_push(tx_push1), .tx_push_data(txd1), .busy(busy1),
    .periodic_en(pen1), .cmd_err(err1), .cmd_drop(drop1)
  );

  int         n_checks = 0;
  int         n_fails  = 0;
  int         cyc = 0;
  int         t0 = 0;
  int         first_push = -1;
  int         busy_fall  = -1;
  logic       busy_prev0 = 1'b0;
  logic [7:0] got0[$], got1[$], expq[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_push0) begin
        got0.push_back(txd0);
        if (first_push < 0) first_push = cyc - t0;
      end
      if (tx_push1) got1.push_back(txd1);
      if (tx_full0) check_eq("push_while_full", {31'd0, tx_push0}, 32'd0);
      if (busy_prev0 && !busy0 && busy_fall < 0) busy_fall = cyc - t0;
    end
    busy_prev0 = busy0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_busy(input int inst);
    return (inst == 0) ? busy0 : busy1;
  endfunction

  task automatic send_cmd(input int inst, input logic [7:0] c);
    if (inst == 0) begin cmd_valid0 = 1'b1; cmd_data0 = c; end
    else begin cmd_valid1 = 1'b1; cmd_data1 = c; end
    step();
    cmd_valid0 = 1'b0;
    cmd_valid1 = 1'b0;
  endtask

  task automatic tick();
    report_tick = 1'b1;
    step();
    report_tick = 1'b0;
  endtask

  task automatic wait_idle(input int inst, input int budget, input bit rand_full);
    int n = 0;
    while (get_busy(inst) && n < budget) begin
      if (rand_full) tx_full0 = ($urandom_range(0, 3) == 0);
      step();
      n++;
    end
    tx_full0 = 1'b0;
    check_eq("idle_reached", {31'd0, get_busy(inst)}, 32'd0);
  endtask

  // Expected report text computed with plain decimal arithmetic.
  task automatic model_frame(input int inst, input int sel);
    int unsigned nd, lim, pw, v, q;
    bit          lb, started;
    nd  = (inst == 0) ? 5 : 4;
    lb  = (inst == 1);
    lim = 1;
    repeat (nd) lim = lim * 10;
    expq.delete();
    for (int k = 0; k < 4; k++) begin
      if (sel < 0 || sel == k) begin
        if (sel < 0 && k > 0) expq.push_back(8'h2C);
        expq.push_back(8'h43);
        expq.push_back(8'(8'h31 + k));
        expq.push_back(8'h3D);
        v       = fv[k];
        pw      = lim;
        started = !lb;
        for (int d = int'(nd) - 1; d >= 0; d--) begin
          pw = pw / 10;
          if (!fok[k])        expq.push_back(8'h2D);
          else if (v >= lim)  expq.push_back(8'h39);
          else begin
            q = (v / pw) % 10;
            if (started || q != 0 || d == 0) begin
              expq.push_back(8'(8'h30 + q));
              started = 1'b1;
            end
          end
        end
      end
    end
    expq.push_back(8'h0D);
    expq.push_back(8'h0A);
  endtask

  task automatic compare_q(input int inst, input string tag);
    logic [7:0] g[$];
    if (inst == 0) g = got0; else g = got1;
    check_eq({tag, "_len"}, g.size(), expq.size());
    for (int i = 0; i < g.size() && i < expq.size(); i++)
      check_eq($sformatf("%s_byte%0d", tag, i), {24'd0, g[i]}, {24'd0, expq[i]});
    if (inst == 0) got0.delete(); else got1.delete();
  endtask

  task automatic check_str(input int inst, input string tag, input string s);
    expq.delete();
    for (int i = 0; i < s.len(); i++) expq.push_back(s[i]);
    compare_q(inst, tag);
  endtask

  task automatic randomize_fields();
    for (int k = 0; k < 4; k++) begin
      case ($urandom_range(0, 5))
        0:       fv[k] = 16'd0;
        1:       fv[k] = 16'd9;
        2:       fv[k] = 16'd9999;
        3:       fv[k] = 16'd10000;
        4:       fv[k] = 16'd65535;
        default: fv[k] = 16'($urandom);
      endcase
    end
    fok = 4'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int n;
    int tc;
    rst = 1'b1; cmd_valid0 = 1'b0; cmd_valid1 = 1'b0; cmd_data0 = 8'h00; cmd_data1 = 8'h00;
    report_tick = 1'b0; tx_full0 = 1'b0; fok = 4'b0000;
    for (int k = 0; k < 4; k++) fv[k] = 16'd0;
    repeat (3) step();
    check_eq("rst_tx_push", {31'd0, tx_push0}, 32'd0);
    check_eq("rst_tx_data", {24'd0, txd0}, 32'd0);
    check_eq("rst_busy", {31'd0, busy0}, 32'd0);
    check_eq("rst_periodic", {31'd0, pen0}, 32'd0);
    check_eq("rst_cmd_err", {31'd0, err0}, 32'd0);
    check_eq("rst_cmd_drop", {31'd0, drop0}, 32'd0);
    rst = 1'b0;
    step();

    // Single report: exact bytes and cycle timing, then back-to-back command at cycle 27.
    fv[0] = 16'd1234; fok = 4'b1111;
    first_push = -1; busy_fall = -1; t0 = cyc;
    send_cmd(0, 8'h31);
    check_eq("busy_cycle1", {31'd0, busy0}, 32'd1);
    wait_idle(0, 200, 1'b0);
    check_str(0, "single_1234", "C1=01234\r\n");
    send_cmd(0, 8'h31);
    check_eq("first_push_cycle", first_push, 32'd17);
    check_eq("busy_fall_cycle", busy_fall, 32'd27);
    check_eq("cmd_at_27_busy", {31'd0, busy0}, 32'd1);
    check_eq("cmd_at_27_no_drop", {31'd0, drop0}, 32'd0);
    wait_idle(0, 200, 1'b0);
    check_str(0, "single_again", "C1=01234\r\n");

    // All-field report with inputs changed mid-frame.
    fv[0] = 16'd0; fv[1] = 16'd65535; fv[2] = 16'd7; fv[3] = 16'd100; fok = 4'b1111;
    send_cmd(0, 8'h41);
    randomize_fields();
    wait_idle(0, 500, 1'b0);
    check_str(0, "all_snapshot", "C1=00000,C2=65535,C3=00007,C4=00100\r\n");

    // Leading-blank instance: short values, saturation and invalid field.
    fv[0] = 16'd7; fv[1] = 16'd0; fv[2] = 16'd12345; fv[3] = 16'd42; fok = 4'b0111;
    send_cmd(1, 8'h41);
    wait_idle(1, 500, 1'b0);
    check_str(1, "lead_blank", "C1=7,C2=0,C3=9999,C4=----\r\n");

    // tx_full held for 50 cycles once five bytes have gone out.
    randomize_fields();
    model_frame(0, -1);
    send_cmd(0, 8'h41);
    n = 0;
    while (got0.size() < 5 && n < 500) begin step(); n++; end
    tx_full0 = 1'b1;
    repeat (50) step();
    check_eq("stall_byte_count", got0.size(), 32'd5);
    tx_full0 = 1'b0;
    wait_idle(0, 500, 1'b0);
    compare_q(0, "stall_frame");

    // Unknown command in IDLE.
    send_cmd(0, 8'h39);
    check_eq("cmd_err_pulse", {31'd0, err0}, 32'd1);
    check_eq("cmd_err_not_busy", {31'd0, busy0}, 32'd0);
    step();
    check_eq("cmd_err_one_cycle", {31'd0, err0}, 32'd0);
    repeat (20) step();
    check_eq("cmd_err_no_push", got0.size(), 32'd0);

    // Command during a frame is dropped without disturbing it.
    randomize_fields();
    model_frame(0, -1);
    send_cmd(0, 8'h41);
    repeat (30) step();
    send_cmd(0, 8'h32);
    check_eq("cmd_drop_pulse", {31'd0, drop0}, 32'd1);
    step();
    check_eq("cmd_drop_one_cycle", {31'd0, drop0}, 32'd0);
    wait_idle(0, 500, 1'b0);
    compare_q(0, "drop_frame");

    // Periodic mode: one all-field frame per tick.
    send_cmd(0, 8'h50);
    check_eq("periodic_on", {31'd0, pen0}, 32'd1);
    check_eq("periodic_no_push", got0.size(), 32'd0);
    for (int t = 0; t < 3; t++) begin
      randomize_fields();
      model_frame(0, -1);
      tc = cyc;
      tick();
      wait_idle(0, 500, 1'b0);
      compare_q(0, $sformatf("tick%0d", t));
      while (cyc - tc < 300) step();
    end

    // Tick coincident with a command: only the command's report appears.
    randomize_fields();
    model_frame(0, 0);
    cmd_valid0 = 1'b1; cmd_data0 = 8'h31; report_tick = 1'b1;
    step();
    cmd_valid0 = 1'b0; report_tick = 1'b0;
    wait_idle(0, 500, 1'b0);
    compare_q(0, "tick_vs_cmd");
    repeat (150) step();
    check_eq("tick_lost", got0.size(), 32'd0);

    send_cmd(0, 8'h50);
    check_eq("periodic_off", {31'd0, pen0}, 32'd0);
    tick();
    repeat (150) step();
    check_eq("tick_ignored_push", got0.size(), 32'd0);
    check_eq("tick_ignored_busy", {31'd0, busy0}, 32'd0);

    // Reset in the middle of a frame.
    send_cmd(0, 8'h50);
    send_cmd(0, 8'h41);
    n = 0;
    while (got0.size() < 3 && n < 500) begin step(); n++; end
    check_eq("push_before_rst", {31'd0, tx_push0}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("rst_mid_push", {31'd0, tx_push0}, 32'd0);
    check_eq("rst_mid_periodic", {31'd0, pen0}, 32'd0);
    check_eq("rst_mid_busy", {31'd0, busy0}, 32'd0);
    step();
    rst = 1'b0;
    got0.delete();
    step();
    randomize_fields();
    model_frame(0, 1);
    send_cmd(0, 8'h32);
    wait_idle(0, 500, 1'b0);
    compare_q(0, "after_rst");

    // Randomized reports on both instances, with random tx_full on the default one.
    for (int it = 0; it < 12; it++) begin
      int inst;
      int sel;
      inst = $urandom_range(0, 1);
      sel  = int'($urandom_range(0, 4)) - 1;
      randomize_fields();
      model_frame(inst, sel);
      send_cmd(inst, (sel < 0) ? 8'h41 : 8'(8'h31 + sel));
      wait_idle(inst, 3000, inst == 0);
      compare_q(inst, $sformatf("rand%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
